// File: rtl/jt5205_adpcm_dec.sv
// JT5205 ADPCM decoder: per sample strobe, decodes one 4-bit nibble into a
// 12-bit signed sample through a four-state IDLE/LOOK/CALC/OUT sequence.
module jt5205_adpcm_dec #(
   parameter int SATURATE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cen,
   input  logic               cen_lo,
   input  logic [3:0]         din,
   input  logic               stop,
   output logic signed [11:0] sound,
   output logic               sample_ok,
   output logic               busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOOK = 2'd1;
   localparam logic [1:0] ST_CALC = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               pend_q, pend_d;
   logic [3:0]         pend_nib_q, pend_nib_d;
   logic [3:0]         nib_q, nib_d;
   logic [5:0]         idx_q, idx_d;
   logic signed [11:0] sound_q, sound_d;
   logic signed [11:0] acc_q, acc_d;
   logic               ok_q, ok_d;
   logic [10:0]        step_q;

   logic               strobe;
   logic [12:0]        s13, mag;
   logic signed [13:0] diff, acc_full;
   logic signed [11:0] acc_sel;

   // step(i) = floor(16 * 1.1^i), i = 0..48
   function automatic logic [10:0] step_rom(input logic [5:0] i);
      case (i)
         6'd0:  step_rom = 11'd16;   6'd1:  step_rom = 11'd17;   6'd2:  step_rom = 11'd19;
         6'd3:  step_rom = 11'd21;   6'd4:  step_rom = 11'd23;   6'd5:  step_rom = 11'd25;
         6'd6:  step_rom = 11'd28;   6'd7:  step_rom = 11'd31;   6'd8:  step_rom = 11'd34;
         6'd9:  step_rom = 11'd37;   6'd10: step_rom = 11'd41;   6'd11: step_rom = 11'd45;
         6'd12: step_rom = 11'd50;   6'd13: step_rom = 11'd55;   6'd14: step_rom = 11'd60;
         6'd15: step_rom = 11'd66;   6'd16: step_rom = 11'd73;   6'd17: step_rom = 11'd80;
         6'd18: step_rom = 11'd88;   6'd19: step_rom = 11'd97;   6'd20: step_rom = 11'd107;
         6'd21: step_rom = 11'd118;  6'd22: step_rom = 11'd130;  6'd23: step_rom = 11'd143;
         6'd24: step_rom = 11'd157;  6'd25: step_rom = 11'd173;  6'd26: step_rom = 11'd190;
         6'd27: step_rom = 11'd209;  6'd28: step_rom = 11'd230;  6'd29: step_rom = 11'd253;
         6'd30: step_rom = 11'd279;  6'd31: step_rom = 11'd307;  6'd32: step_rom = 11'd337;
         6'd33: step_rom = 11'd371;  6'd34: step_rom = 11'd408;  6'd35: step_rom = 11'd449;
         6'd36: step_rom = 11'd494;  6'd37: step_rom = 11'd544;  6'd38: step_rom = 11'd598;
         6'd39: step_rom = 11'd658;  6'd40: step_rom = 11'd724;  6'd41: step_rom = 11'd796;
         6'd42: step_rom = 11'd876;  6'd43: step_rom = 11'd963;  6'd44: step_rom = 11'd1060;
         6'd45: step_rom = 11'd1166; 6'd46: step_rom = 11'd1282; 6'd47: step_rom = 11'd1411;
         default: step_rom = 11'd1552;
      endcase
   endfunction

   // Step-index adaptation from the nibble magnitude, clamped to 0..48
   function automatic logic [5:0] idx_next(input logic [5:0] i, input logic [2:0] m);
      logic signed [7:0] t;
      t = $signed({2'b00, i});
      case (m)
         3'd4:    t = t + 8'sd2;
         3'd5:    t = t + 8'sd4;
         3'd6:    t = t + 8'sd6;
         3'd7:    t = t + 8'sd8;
         default: t = t - 8'sd1;
      endcase
      if (t < 8'sd0)       idx_next = 6'd0;
      else if (t > 8'sd48) idx_next = 6'd48;
      else                 idx_next = t[5:0];
   endfunction

   // Clamp the 14-bit accumulator into the 12-bit signed output range
   function automatic logic signed [11:0] sat12(input logic signed [13:0] a);
      if (a > 14'sd2047)       sat12 = 12'sd2047;
      else if (a < -14'sd2048) sat12 = 12'h800;
      else                     sat12 = a[11:0];
   endfunction

   assign strobe    = cen & cen_lo;
   assign sound     = sound_q;
   assign sample_ok = ok_q;
   assign busy      = (state_q != ST_IDLE) | pend_q;

   // Difference and accumulation from the registered step and latched nibble
   always_comb begin
      s13      = {2'b00, step_q};
      mag      = (s13 >> 3)
               + (nib_q[0] ? (s13 >> 2) : 13'd0)
               + (nib_q[1] ? (s13 >> 1) : 13'd0)
               + (nib_q[2] ? s13 : 13'd0);
      diff     = nib_q[3] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      acc_full = $signed({{2{sound_q[11]}}, sound_q}) + diff;
      acc_sel  = (SATURATE != 0) ? sat12(acc_full) : acc_full[11:0];
   end

   // Decode sequencer; stop overrides everything and aborts any decode
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_nib_d = pend_nib_q;
      nib_d      = nib_q;
      idx_d      = idx_q;
      sound_d    = sound_q;
      acc_d      = acc_q;
      ok_d       = 1'b0;
      if (stop) begin
         state_d = ST_IDLE;
         pend_d  = 1'b0;
         idx_d   = 6'd0;
         sound_d = 12'sd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (strobe) begin
                  nib_d   = din;
                  state_d = ST_LOOK;
               end
            end
            ST_LOOK, ST_CALC: begin
               if (strobe) begin
                  pend_d     = 1'b1;
                  pend_nib_d = din;
               end
               if (state_q == ST_CALC) begin
                  acc_d   = acc_sel;
                  idx_d   = idx_next(idx_q, nib_q[2:0]);
                  state_d = ST_OUT;
               end else begin
                  state_d = ST_CALC;
               end
            end
            default: begin
               sound_d = acc_q;
               ok_d    = 1'b1;
               if (pend_q) begin
                  // Older pending nibble goes first; a same-cycle strobe refills pending
                  nib_d   = pend_nib_q;
                  state_d = ST_LOOK;
                  if (strobe) pend_nib_d = din;
                  else        pend_d     = 1'b0;
               end else if (strobe) begin
                  nib_d   = din;
                  state_d = ST_LOOK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Control and output state with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         idx_q   <= 6'd0;
         sound_q <= 12'sd0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         sound_q <= sound_d;
         ok_q    <= ok_d;
      end
   end

   // Datapath registers and the registered step ROM read
   always_ff @(posedge clk) begin
      nib_q      <= nib_d;
      pend_nib_q <= pend_nib_d;
      acc_q      <= acc_d;
      step_q     <= step_rom(idx_q);
   end

endmodule
